// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with PC, IF/ID register, stall and branch/jump redirects.
// Optional IF_RANGE_CHECK_EN adds a sticky fetch_fault for PCs beyond the instruction memory.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = 6,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_data,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
`ifdef IF_RANGE_CHECK_EN
  output logic             fetch_fault,
`endif
  output logic [31:0]      fetch_count
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t state;
  logic [31:0] pc_inc;
  assign pc_inc  = pc + 32'd4;
  assign im_addr = pc[IM_AW+1:2];
`ifdef IF_RANGE_CHECK_EN
  logic oor;
  assign oor = |pc[31:IM_AW+2];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      fetch_count <= 32'd0;
`ifdef IF_RANGE_CHECK_EN
      fetch_fault <= 1'b0;
`endif
    end else if (state == BOOT) begin
      state <= RUN;
    end else if (branch_taken || jump) begin
      // branch is the older instruction, so it wins over a same-cycle jump
      pc          <= (branch_taken ? branch_target : jump_target) & ~32'd3;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc <= pc_inc;
`ifdef IF_RANGE_CHECK_EN
      if (oor) begin
        fetch_fault <= 1'b1;
        if_id_instr <= NOP_WORD;
        if_id_pc4   <= 32'd0;
        if_id_valid <= 1'b0;
      end else
`endif
      begin
        if_id_instr <= im_data;
        if_id_pc4   <= pc_inc;
        if_id_valid <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end
endmodule
